// File: rtl/doa_pkg.sv
// Shared types and defaults for the DOA frame sequencer: FSM states, result record,
// and a saturating counter helper.
package doa_pkg;

  localparam int DOA_NBINS  = 1024;
  localparam int DOA_ADDR_W = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_DETECT = 2'd2,
    S_WEIGH  = 2'd3
  } doa_state_t;

  typedef struct packed {
    logic [DOA_ADDR_W-1:0] bin;
    logic [3:0]            bnum;
    logic [7:0]            doa;
  } doa_result_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/doa_watchdog.sv
// Cycle watchdog shared by the DETECT and WEIGH phases: expire_o is high on the
// TIMEOUT-th enabled cycle after the last clear.
module doa_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A clear in the same cycle restarts the window, so it masks expiry.
  assign expire_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/doa_frame_ctrl.sv
// Frame sequencer for the DOA pipeline: fills the FFT RAMs, runs the peak detector,
// then weightblock, and publishes the result in a held valid/ack register.
module doa_frame_ctrl
  import doa_pkg::*;
#(
  parameter int NBINS   = DOA_NBINS,
  parameter int ADDR_W  = DOA_ADDR_W,
  parameter int MIN_BIN = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fft_valid,
  input  logic              fft_sop,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic              det_start,
  input  logic              det_done,
  input  logic [ADDR_W-1:0] det_maxbin,
  output logic              wb_start,
  output logic [ADDR_W-1:0] wb_maxbin,
  input  logic              wb_done,
  input  logic [3:0]        wb_bnum,
  input  logic [7:0]        wb_doa,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_bin,
  output logic [3:0]        res_bnum,
  output logic [7:0]        res_doa,
  input  logic              res_ack,
  output logic              res_overrun,
  output logic [7:0]        drop_cnt,
  output logic              timeout_err,
  output logic              busy,
  output doa_state_t        dbg_state
);

  // Handshakes: det_start/wb_start and det_done/wb_done are single-cycle pulses
  // with data valid only alongside them; res_valid holds until a cycle with
  // res_ack, and a new result in that same cycle keeps it set.

  doa_state_t        state_q;
  logic              wren_q;
  logic [ADDR_W-1:0] wraddr_q;
  logic              det_start_q;
  logic              wb_start_q;
  logic [ADDR_W-1:0] wb_maxbin_q;
  logic              res_valid_q;
  doa_result_t       res_q;
  logic              overrun_q;
  logic [7:0]        drop_q;
  logic              to_err_q;
  logic              busy_q;

  logic sop;
  logic fill_last;
  logic det_accept;
  logic wd_clr;
  logic wd_en;
  logic wd_expire;

  assign sop        = fft_valid && fft_sop;
  assign fill_last  = wren_q && (wraddr_q == ADDR_W'(NBINS - 1));
  assign det_accept = det_done && (det_maxbin >= ADDR_W'(MIN_BIN));
  assign wd_clr     = ((state_q == S_FILL) && fill_last) ||
                      ((state_q == S_DETECT) && det_accept);
  assign wd_en      = (state_q == S_DETECT) || (state_q == S_WEIGH);

  doa_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wren_q      <= 1'b0;
      wraddr_q    <= '0;
      det_start_q <= 1'b0;
      wb_start_q  <= 1'b0;
      wb_maxbin_q <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      overrun_q   <= 1'b0;
      drop_q      <= '0;
      to_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wren_q      <= 1'b0;
      det_start_q <= 1'b0;
      wb_start_q  <= 1'b0;
      if (res_ack && res_valid_q) res_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (sop) begin
            if (enable) begin
              state_q  <= S_FILL;
              busy_q   <= 1'b1;
              wren_q   <= 1'b1;
              wraddr_q <= '0;
            end else begin
              drop_q <= sat_inc8(drop_q);
            end
          end
        end
        S_FILL: begin
          if (fill_last) begin
            state_q     <= S_DETECT;
            det_start_q <= 1'b1;
            if (sop) drop_q <= sat_inc8(drop_q);
          end else if (sop) begin
            // Resync: a new start-of-frame restarts the fill from bin 0.
            wren_q   <= 1'b1;
            wraddr_q <= '0;
            drop_q   <= sat_inc8(drop_q);
          end else if (fft_valid) begin
            wren_q   <= 1'b1;
            wraddr_q <= wraddr_q + ADDR_W'(1);
          end
        end
        S_DETECT: begin
          if (det_done) begin
            if (det_accept) begin
              wb_maxbin_q <= det_maxbin;
              wb_start_q  <= 1'b1;
              state_q     <= S_WEIGH;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else if (wd_expire) begin
            to_err_q <= 1'b1;
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
          end
          if (sop) drop_q <= sat_inc8(drop_q);
        end
        S_WEIGH: begin
          if (wb_done) begin
            res_q       <= '{bin: DOA_ADDR_W'(wb_maxbin_q), bnum: wb_bnum, doa: wb_doa};
            res_valid_q <= 1'b1;
            if (res_valid_q && !res_ack) overrun_q <= 1'b1;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
          end else if (wd_expire) begin
            to_err_q <= 1'b1;
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
          end
          if (sop) drop_q <= sat_inc8(drop_q);
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ram_wren    = wren_q;
  assign ram_wraddr  = wraddr_q;
  assign det_start   = det_start_q;
  assign wb_start    = wb_start_q;
  assign wb_maxbin   = wb_maxbin_q;
  assign res_valid   = res_valid_q;
  assign res_bin     = ADDR_W'(res_q.bin);
  assign res_bnum    = res_q.bnum;
  assign res_doa     = res_q.doa;
  assign res_overrun = overrun_q;
  assign drop_cnt    = drop_q;
  assign timeout_err = to_err_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_doa_frame_ctrl.sv
// Bench for doa_frame_ctrl: table of whole-frame scenarios, hand sequences for
// saturation/resync/reset, and randomized frames against a transaction-level model.
module tb_doa_frame_ctrl;
  import doa_pkg::*;

  localparam int NB = 1024;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset, enable, fft_valid, fft_sop;
  logic       ram_wren, det_start, det_done, wb_start, wb_done;
  logic [9:0] ram_wraddr, det_maxbin, wb_maxbin, res_bin;
  logic [3:0] wb_bnum, res_bnum;
  logic [7:0] wb_doa, res_doa, drop_cnt;
  logic       res_valid, res_ack, res_overrun, timeout_err, busy;
  doa_state_t dbg_state;

  doa_frame_ctrl #(.NBINS(NB), .ADDR_W(10), .MIN_BIN(1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fft_valid(fft_valid), .fft_sop(fft_sop),
    .ram_wren(ram_wren), .ram_wraddr(ram_wraddr), .det_start(det_start),
    .det_done(det_done), .det_maxbin(det_maxbin), .wb_start(wb_start),
    .wb_maxbin(wb_maxbin), .wb_done(wb_done), .wb_bnum(wb_bnum), .wb_doa(wb_doa),
    .res_valid(res_valid), .res_bin(res_bin), .res_bnum(res_bnum), .res_doa(res_doa),
    .res_ack(res_ack), .res_overrun(res_overrun), .drop_cnt(drop_cnt),
    .timeout_err(timeout_err), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / global bound
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // scoreboard state
  logic [9:0] exp_q[$];
  int n_chk = 0, n_pass = 0;
  int ds_cnt, wb_cnt;

  // reference model of the published result
  bit         m_valid, m_ovr, m_to;
  logic [9:0] m_bin;
  logic [3:0] m_bnum;
  logic [7:0] m_doa;
  int         m_drop;

  typedef struct {
    int gap_at, gap_len, det_lat;
    logic [9:0] mb;
    int wb_lat;
    logic [3:0] bn;
    logic [7:0] dv;
    bit ack_mid, ack_done, sop_weigh;
    bit e_valid;
    logic [9:0] e_bin;
    logic [3:0] e_bnum;
    logic [7:0] e_doa;
    bit e_ovr, e_to;
    int e_drop;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d, required %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    logic [9:0] e;
    @(posedge clk);
    #1;
    if (det_start === 1'b1) ds_cnt++;
    if (wb_start === 1'b1) wb_cnt++;
    if (ram_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got write at addr %0d, required none", ram_wraddr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_wraddr), 32'(e));
      end
    end
  endtask

  task automatic idle_inputs();
    enable = 1'b1; fft_valid = 1'b0; fft_sop = 1'b0; det_done = 1'b0;
    det_maxbin = '0; wb_done = 1'b0; wb_bnum = '0; wb_doa = '0; res_ack = 1'b0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wren"}, 32'(ram_wren), 0);
    chk({tag, "_wraddr"}, 32'(ram_wraddr), 0);
    chk({tag, "_det_start"}, 32'(det_start), 0);
    chk({tag, "_wb_start"}, 32'(wb_start), 0);
    chk({tag, "_wb_maxbin"}, 32'(wb_maxbin), 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_bin"}, 32'(res_bin), 0);
    chk({tag, "_res_bnum"}, 32'(res_bnum), 0);
    chk({tag, "_res_doa"}, 32'(res_doa), 0);
    chk({tag, "_overrun"}, 32'(res_overrun), 0);
    chk({tag, "_drop"}, 32'(drop_cnt), 0);
    chk({tag, "_timeout"}, 32'(timeout_err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic check_res(input bit v, input logic [9:0] b, input logic [3:0] bn,
                           input logic [7:0] d, input bit ovr, input bit to, input int drop);
    chk("res_valid", 32'(res_valid), 32'(v));
    chk("res_bin", 32'(res_bin), 32'(b));
    chk("res_bnum", 32'(res_bnum), 32'(bn));
    chk("res_doa", 32'(res_doa), 32'(d));
    chk("res_overrun", 32'(res_overrun), 32'(ovr));
    chk("timeout_err", 32'(timeout_err), 32'(to));
    chk("drop_cnt", 32'(drop_cnt), 32'(drop));
    chk("busy_after_frame", 32'(busy), 0);
  endtask

  // driver: one full frame of NB samples, optional gap, optional enable drop
  task automatic send_frame(input int gap_at, input int gap_len, input bit en_mid);
    for (int a = 0; a < NB; a++) exp_q.push_back(10'(a));
    fft_valid = 1'b1; fft_sop = 1'b1;
    tick();
    fft_sop = 1'b0;
    if (en_mid) enable = 1'b0;
    for (int a = 1; a < NB; a++) begin
      if (a == gap_at && gap_len > 0) begin
        fft_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("gap_hold_addr", 32'(ram_wraddr), 32'(a - 1));
          chk("gap_no_wren", 32'(ram_wren), 0);
        end
        fft_valid = 1'b1;
      end
      tick();
    end
    fft_valid = 1'b0;
    enable = 1'b1;
    tick();
    chk("det_start_after_last", 32'(det_start), 1);
    chk("no_wren_in_detect", 32'(ram_wren), 0);
    chk("writes_left", 32'(exp_q.size()), 0);
  endtask

  task automatic run_frame(input int gap_at, input int gap_len, input int det_lat,
                           input logic [9:0] mb, input int wb_lat, input logic [3:0] bn,
                           input logic [7:0] dv, input bit ack_mid, input bit ack_done,
                           input bit sop_weigh, input bit en_mid);
    ds_cnt = 0; wb_cnt = 0;
    send_frame(gap_at, gap_len, en_mid);
    if (det_lat >= TO) begin
      repeat (TO - 1) tick();
      chk("det_wait_busy", 32'(busy), 1);
      tick();
      chk("det_timeout_flag", 32'(timeout_err), 1);
    end else begin
      repeat (det_lat) tick();
      det_done = 1'b1; det_maxbin = mb;
      tick();
      det_done = 1'b0;
      if (mb < 10'd1) begin
        chk("dc_reject_idle", 32'(busy), 0);
        chk("dc_reject_no_wb", 32'(wb_start), 0);
      end else begin
        chk("wb_start_pulse", 32'(wb_start), 1);
        chk("wb_maxbin", 32'(wb_maxbin), 32'(mb));
        if (wb_lat >= TO) begin
          for (int i = 0; i < TO; i++) begin
            if (sop_weigh && i == 0) begin fft_valid = 1'b1; fft_sop = 1'b1; end
            tick();
            fft_valid = 1'b0; fft_sop = 1'b0;
            if (i == TO - 2) chk("wb_wait_busy", 32'(busy), 1);
          end
          chk("wb_timeout_flag", 32'(timeout_err), 1);
        end else begin
          for (int i = 0; i < wb_lat; i++) begin
            if (sop_weigh && i == 0) begin fft_valid = 1'b1; fft_sop = 1'b1; end
            if (ack_mid && i == wb_lat - 1) res_ack = 1'b1;
            tick();
            fft_valid = 1'b0; fft_sop = 1'b0; res_ack = 1'b0;
          end
          chk("wb_maxbin_held", 32'(wb_maxbin), 32'(mb));
          wb_done = 1'b1; wb_bnum = bn; wb_doa = dv; res_ack = ack_done;
          tick();
          wb_done = 1'b0; res_ack = 1'b0;
        end
      end
    end
    chk("det_start_count", 32'(ds_cnt), 1);
    chk("wb_start_count", 32'(wb_cnt), (det_lat < TO && mb >= 10'd1) ? 1 : 0);
  endtask

  // transaction-level reference: what the consumer should see after one frame
  task automatic model_frame(input int det_lat, input logic [9:0] mb, input int wb_lat,
                             input logic [3:0] bn, input logic [7:0] dv, input bit ack_mid,
                             input bit ack_done, input bit sop_weigh);
    if (det_lat >= TO) begin m_to = 1'b1; return; end
    if (mb < 10'd1) return;
    if (sop_weigh && wb_lat >= 1) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
    if (wb_lat >= TO) begin m_to = 1'b1; return; end
    if (ack_mid) m_valid = 1'b0;
    if (m_valid && !ack_done) m_ovr = 1'b1;
    m_valid = 1'b1; m_bin = mb; m_bnum = bn; m_doa = dv;
  endtask

  initial begin
    int gap_at, gap_len, det_lat, wb_lat;
    logic [9:0] mb;
    logic [3:0] bn;
    logic [7:0] dv;
    bit am, ad, sw, em;

    //            gap  len det  mb   wb  bn  dv   am ad sw  v  bin  bn  doa  ovr to drop
    vecs[0] = '{0,   0,  2,  44,  3,  5,  60,  0, 0, 1,  1, 44,  5,  60,  0, 0, 1};
    vecs[1] = '{500, 3,  0,  0,   2,  0,  0,   0, 0, 0,  1, 44,  5,  60,  0, 0, 1};
    vecs[2] = '{0,   0,  15, 1,   1,  9,  11,  0, 1, 0,  1, 1,   9,  11,  0, 0, 1};
    vecs[3] = '{0,   0,  3,  300, 4,  2,  128, 1, 0, 0,  1, 300, 2,  128, 0, 0, 1};
    vecs[4] = '{0,   0,  1,  100, 15, 3,  200, 0, 0, 0,  1, 100, 3,  200, 1, 0, 1};
    vecs[5] = '{0,   0,  1,  50,  16, 1,  1,   0, 0, 1,  1, 100, 3,  200, 1, 1, 2};
    vecs[6] = '{0,   0,  20, 8,   0,  0,  0,   0, 0, 0,  1, 100, 3,  200, 1, 1, 2};
    vecs[7] = '{0,   0,  0,  1023, 0, 15, 255, 0, 0, 0,  1, 1023, 15, 255, 1, 1, 2};

    reset_dut();
    check_zero("reset");

    foreach (vecs[k]) begin
      run_frame(vecs[k].gap_at, vecs[k].gap_len, vecs[k].det_lat, vecs[k].mb, vecs[k].wb_lat,
                vecs[k].bn, vecs[k].dv, vecs[k].ack_mid, vecs[k].ack_done, vecs[k].sop_weigh, 1'b0);
      check_res(vecs[k].e_valid, vecs[k].e_bin, vecs[k].e_bnum, vecs[k].e_doa,
                vecs[k].e_ovr, vecs[k].e_to, vecs[k].e_drop);
    end

    // sops while disabled: dropped, never written, counter saturates
    enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      fft_valid = 1'b1; fft_sop = 1'b1;
      tick();
      if (i == 99) chk("drop_cnt_mid", 32'(drop_cnt), 102);
    end
    idle_inputs();
    tick();
    chk("drop_cnt_sat", 32'(drop_cnt), 255);
    chk("busy_while_disabled", 32'(busy), 0);

    // resync mid-FILL, then reset at addr 500
    reset_dut();
    for (int a = 0; a <= 100; a++) exp_q.push_back(10'(a));
    for (int a = 0; a <= 500; a++) exp_q.push_back(10'(a));
    fft_valid = 1'b1; fft_sop = 1'b1;
    tick();
    fft_sop = 1'b0;
    repeat (100) tick();
    fft_sop = 1'b1;
    tick();
    fft_sop = 1'b0;
    chk("resync_addr0", 32'(ram_wraddr), 0);
    chk("resync_drop", 32'(drop_cnt), 1);
    repeat (500) tick();
    chk("fill_addr500", 32'(ram_wraddr), 500);
    chk("fill_busy", 32'(busy), 1);
    fft_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("midfill_reset");
    chk("midfill_writes_left", 32'(exp_q.size()), 0);

    // randomized frames against the model
    reset_dut();
    m_valid = 0; m_ovr = 0; m_to = 0; m_bin = '0; m_bnum = '0; m_doa = '0; m_drop = 0;
    for (int f = 0; f < 8; f++) begin
      gap_at  = $urandom_range(1, NB - 2);
      gap_len = $urandom_range(0, 4);
      det_lat = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
      mb      = ($urandom_range(0, 4) == 0) ? 10'd0 : 10'($urandom_range(0, NB - 1));
      wb_lat  = ($urandom_range(0, 4) == 0) ? TO : $urandom_range(0, TO - 1);
      bn      = 4'($urandom_range(0, 15));
      dv      = 8'($urandom_range(0, 255));
      am      = (wb_lat >= 1) && ($urandom_range(0, 1) == 1);
      ad      = ($urandom_range(0, 1) == 1);
      sw      = (wb_lat >= 1) && ($urandom_range(0, 1) == 1);
      em      = ($urandom_range(0, 1) == 1);
      run_frame(gap_at, gap_len, det_lat, mb, wb_lat, bn, dv, am, ad, sw, em);
      model_frame(det_lat, mb, wb_lat, bn, dv, am, ad, sw);
      check_res(m_valid, m_bin, m_bnum, m_doa, m_ovr, m_to, m_drop);

      // stray done pulses in IDLE, then an optional ack
      det_done = 1'b1; wb_done = 1'b1; det_maxbin = 10'($urandom_range(1, NB - 1));
      wb_bnum = 4'($urandom_range(0, 15)); wb_doa = 8'($urandom_range(0, 255));
      tick();
      idle_inputs();
      chk("stray_no_wb_start", 32'(wb_start), 0);
      if ($urandom_range(0, 1) == 1) begin
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
        m_valid = 1'b0;
      end
      repeat ($urandom_range(1, 3)) tick();
      check_res(m_valid, m_bin, m_bnum, m_doa, m_ovr, m_to, m_drop);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
